// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read and write controllers.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 8;
  localparam int FIFO_DATA_W = 8;

  // Pointers carry one extra wrap bit above the storage address.
  typedef logic [FIFO_ADDR_W:0]   ptr_t;
  typedef logic [FIFO_DATA_W-1:0] data_t;

  // Output register state: IDLE holds nothing, FULL holds the head word.
  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } out_state_e;

endpackage : fifo_pkg

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: owns the read pointer, prefetches the head
// word into a show-ahead register, and reports occupancy and overrun.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   wr_ptr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   rd_ptr,
  output logic [ADDR_W:0]   mem_level,
  output logic              empty,
  output logic              overrun
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  out_state_e        state_q, state_d;
  logic [ADDR_W:0]   rd_ptr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              overrun_q;

  logic mem_empty;
  logic pop;
  logic load;
  logic level_over;

  // The array is read asynchronously at the current pointer, so the head
  // word is available in the same cycle the pointer moves.
  assign mem_addr  = rd_ptr_q[ADDR_W-1:0];
  assign mem_level = wr_ptr - rd_ptr_q;
  assign out_valid = (state_q == FULL);
  assign empty     = mem_empty & ~out_valid;
  assign out_data  = out_data_q;
  assign rd_ptr    = rd_ptr_q;
  assign overrun   = overrun_q;

  // Handshake decode and output-register next state.
  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so
    // no path can leave it unassigned and infer a latch.
    mem_empty  = (rd_ptr_q == wr_ptr);
    pop        = out_valid & out_ready;
    load       = ~mem_empty & (~out_valid | pop);
    // More than a full array of unread words means the writer lapped us.
    level_over = mem_level[ADDR_W] & (|mem_level[ADDR_W-1:0]);
    state_d    = state_q;
    case (state_q)
      IDLE:    if (load)        state_d = FULL;
      FULL:    if (pop && !load) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Output-register state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Read pointer and head-word register; flush resynchronises to the writer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      out_data_q <= '0;
    end else if (flush) begin
      rd_ptr_q   <= wr_ptr;
    end else if (load) begin
      rd_ptr_q   <= rd_ptr_q + PTR_ONE;
      out_data_q <= mem_rdata;
    end
  end

  // Sticky overrun flag, cleared only by flush or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          overrun_q <= 1'b0;
    else if (flush)      overrun_q <= 1'b0;
    else if (level_over) overrun_q <= 1'b1;
  end

endmodule : fifo_rd_ctrl

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural 256x8 storage array.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] wr_ptr;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       flush;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] rd_ptr;
  logic [8:0] mem_level;
  logic       empty;
  logic       overrun;

  logic [7:0] mem [256];

  int tests_run    = 0;
  int tests_failed = 0;

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_ptr    (wr_ptr),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_ptr    (rd_ptr),
    .mem_level (mem_level),
    .empty     (empty),
    .overrun   (overrun)
  );

  // Writer model: store at the write address and advance the pointer.
  task automatic write_word(input logic [7:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 9'd1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; wr_ptr = '0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_ptr = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || rd_ptr !== 9'h000 || empty !== 1'b1 ||
        mem_addr !== 8'h00 || overrun !== 1'b0 || out_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b rd_ptr=%h empty=%b addr=%h ovr=%b data=%h, want 0 000 1 00 0 00",
               out_valid, rd_ptr, empty, mem_addr, overrun, out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    out_ready = 1'b0;
    write_word(8'hA5);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || rd_ptr !== 9'h001 ||
        mem_level !== 9'h000 || empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_word: valid=%b data=%h rd_ptr=%h level=%h empty=%b, want 1 a5 001 000 0",
               out_valid, out_data, rd_ptr, mem_level, empty);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || rd_ptr !== 9'h001) begin
        tests_failed++;
        $display("FAIL single_hold cycle %0d: valid=%b data=%h rd_ptr=%h, want 1 a5 001",
                 i, out_valid, out_data, rd_ptr);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_drain: valid=%b empty=%b, want 0 1", out_valid, empty);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      write_word(8'(i));
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        tests_failed++;
        $display("FAIL stream_pop %0d: valid=%b data=%h, want 1 %h", i, out_valid, out_data, 8'(i));
      end
      @(negedge clk);
    end
    tests_run++;
    if (out_valid !== 1'b0 || empty !== 1'b1 || rd_ptr !== 9'd17) begin
      tests_failed++;
      $display("FAIL stream_end: valid=%b empty=%b rd_ptr=%h, want 0 1 011", out_valid, empty, rd_ptr);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int         rd_idx = 0;
    int         wr_idx = 0;
    bit         seen_wrap = 1'b0;
    logic [8:0] prev_ptr;
    apply_reset();
    out_ready = 1'b1;
    prev_ptr  = 9'h000;
    for (int cyc = 0; cyc < 400 && rd_idx < 300; cyc++) begin
      if (prev_ptr == 9'h0FF && !seen_wrap) begin
        seen_wrap = 1'b1;
        tests_run++;
        if (rd_ptr !== 9'h100 || mem_addr !== 8'h00) begin
          tests_failed++;
          $display("FAIL wrap_step: rd_ptr=%h addr=%h, want 100 00", rd_ptr, mem_addr);
        end
      end
      prev_ptr = rd_ptr;
      if (out_valid) begin
        tests_run++;
        if (out_data !== 8'(rd_idx * 3 + 1)) begin
          tests_failed++;
          $display("FAIL wrap_data %0d: got %h want %h", rd_idx, out_data, 8'(rd_idx * 3 + 1));
        end
        rd_idx++;
      end
      if (wr_idx < 300) begin
        write_word(8'(wr_idx * 3 + 1));
        wr_idx++;
      end
      @(negedge clk);
    end
    tests_run++;
    if (rd_idx != 300 || !seen_wrap || rd_ptr !== 9'h12C || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_end: words=%0d wrapped=%0d rd_ptr=%h empty=%b, want 300 1 12c 1",
               rd_idx, seen_wrap, rd_ptr, empty);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int         rd_idx = 0;
    int         wr_idx = 0;
    bit         held = 1'b0;
    logic [7:0] held_data = 8'h00;
    for (int cyc = 0; cyc < 600 && rd_idx < 40; cyc++) begin
      if (held) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== held_data) begin
          tests_failed++;
          $display("FAIL bp_stable: valid=%b data=%h, want 1 %h", out_valid, out_data, held_data);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        tests_run++;
        if (out_data !== 8'(8'hC3 ^ rd_idx)) begin
          tests_failed++;
          $display("FAIL bp_data %0d: got %h want %h", rd_idx, out_data, 8'(8'hC3 ^ rd_idx));
        end
        rd_idx++;
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      if (wr_idx < 40 && $urandom_range(0, 3) != 0) begin
        write_word(8'(8'hC3 ^ wr_idx));
        wr_idx++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    tests_run++;
    if (rd_idx != 40 || empty !== 1'b1 || rd_ptr !== wr_ptr) begin
      tests_failed++;
      $display("FAIL bp_end: words=%0d empty=%b rd_ptr=%h, want 40 1 %h", rd_idx, empty, rd_ptr, wr_ptr);
    end
  endtask

  task automatic test_overrun_flush();
    logic [8:0] base;
    base      = wr_ptr;
    out_ready = 1'b0;
    // Exactly a full array: legal, one word gets prefetched.
    wr_ptr = base + 9'd256;
    @(negedge clk);
    tests_run++;
    if (overrun !== 1'b0 || out_valid !== 1'b1 || rd_ptr !== base + 9'd1 || mem_level !== 9'd255) begin
      tests_failed++;
      $display("FAIL level_256: ovr=%b valid=%b rd_ptr=%h level=%h, want 0 1 %h 0ff",
               overrun, out_valid, rd_ptr, mem_level, base + 9'd1);
    end
    // Writer laps the reader: 257 unread words in the array.
    wr_ptr = base + 9'd258;
    @(negedge clk);
    tests_run++;
    if (overrun !== 1'b1 || rd_ptr !== base + 9'd1 || mem_level !== 9'd257) begin
      tests_failed++;
      $display("FAIL overrun_set: ovr=%b rd_ptr=%h level=%h, want 1 %h 101",
               overrun, rd_ptr, mem_level, base + 9'd1);
    end
    // Back to a legal level; the flag must stay set.
    wr_ptr = base + 9'd257;
    repeat (2) @(negedge clk);
    tests_run++;
    if (overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_sticky: ovr=%b, want 1", overrun);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if (rd_ptr !== wr_ptr || out_valid !== 1'b0 || overrun !== 1'b0 || empty !== 1'b1 ||
        mem_level !== 9'd0) begin
      tests_failed++;
      $display("FAIL flush: rd_ptr=%h valid=%b ovr=%b empty=%b level=%h, want %h 0 0 1 000",
               rd_ptr, out_valid, overrun, empty, mem_level, wr_ptr);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    write_word(8'h3C);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
      tests_failed++;
      $display("FAIL async_pre: valid=%b data=%h, want 1 3c", out_valid, out_data);
    end
    #2;
    rst_n  = 1'b0;
    wr_ptr = '0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || rd_ptr !== 9'h000 || empty !== 1'b1 || out_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%b rd_ptr=%h empty=%b data=%h, want 0 000 1 00",
               out_valid, rd_ptr, empty, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_streaming();
    test_wrap();
    test_backpressure();
    test_overrun_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_fifo_rd_ctrl
